// File: rtl/serving_wb_loader_pkg.sv
// ============================================================================
// Module      : serving_wb_loader_pkg
// Description : Shared types and constants for the serving SRAM image loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serving_wb_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        BUS  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [3:0] SEL_ALL        = 4'b1111;
    localparam int         BYTES_PER_WORD = 4;

endpackage

`default_nettype wire

// File: rtl/serving_wb_loader_pack.sv
// ============================================================================
// Module      : serving_wb_loader_pack
// Description : Little-endian byte-to-word assembler with valid/ready input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serving_wb_loader_pack (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    import serving_wb_loader_pkg::*;

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  idx_q,  idx_d;
    logic [31:0] word_q, word_d;
    logic        w_accept;

    assign w_accept = i_en & i_valid;
    assign o_ready  = i_en;
    assign o_word   = word_q;

    always_comb begin
        idx_d        = idx_q;
        word_d       = word_q;
        o_word_valid = 1'b0;
        if (i_clear) begin
            idx_d = 2'd0;
        end else if (w_accept) begin
            // Byte idx lands in bits [8*idx +: 8]; index wraps naturally at 4.
            word_d[8*idx_q +: 8] = i_data;
            idx_d                = idx_q + 2'd1;
            o_word_valid         = (idx_q == LAST_IDX);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx_q  <= 2'd0;
            word_q <= 32'd0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/serving_wb_loader.sv
// ============================================================================
// Module      : serving_wb_loader
// Description : Wishbone initiator that writes or verifies a byte-stream image
//               into the serving SRAM while holding the CPU in reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serving_wb_loader #(
    parameter int DEPTH   = 256,
    parameter int AW      = $clog2(DEPTH),
    parameter int TIMEOUT = 64
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_verify,
    input  logic [AW-3:0] i_base,
    input  logic [AW-2:0] i_len,
    input  logic [7:0]    i_data,
    input  logic          i_valid,
    output logic          o_ready,
    output logic [AW-3:0] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_stb,
    input  logic [31:0]   i_wb_rdt,
    input  logic          i_wb_ack,
    output logic          o_cpu_rst,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    import serving_wb_loader_pkg::*;

    localparam int          TW      = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    state_e        state_q,   state_d;
    logic          verify_q,  verify_d;
    logic [AW-3:0] base_q,    base_d;
    logic [AW-2:0] len_q,     len_d;
    logic [AW-2:0] count_q,   count_d;
    logic [TW-1:0] to_q,      to_d;
    logic          err_q,     err_d;
    logic          cpu_rst_q, cpu_rst_d;

    logic          w_start_acc;
    logic          w_pack_clear;
    logic          w_pack_en;
    logic [31:0]   w_word;
    logic          w_word_valid;
    logic [AW-2:0] w_count_inc;

    serving_wb_loader_pack u_pack (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (w_pack_clear),
        .i_en         (w_pack_en),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    assign w_start_acc = (state_q == IDLE) & i_start;
    assign w_pack_en   = (state_q == FILL);
    assign w_count_inc = count_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        verify_d     = verify_q;
        base_d       = base_q;
        len_d        = len_q;
        count_d      = count_q;
        to_d         = to_q;
        err_d        = err_q;
        cpu_rst_d    = cpu_rst_q;
        w_pack_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    verify_d     = i_verify;
                    base_d       = i_base;
                    len_d        = i_len;
                    count_d      = '0;
                    to_d         = '0;
                    err_d        = 1'b0;
                    cpu_rst_d    = 1'b1;
                    w_pack_clear = 1'b1;
                    state_d      = (i_len == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (w_word_valid) begin
                    to_d    = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                // Ack wins over a timeout that expires in the same cycle.
                if (i_wb_ack) begin
                    to_d    = '0;
                    count_d = w_count_inc;
                    if (verify_q && (i_wb_rdt != w_word)) begin
                        err_d = 1'b1;
                    end
                    state_d = (w_count_inc == len_q) ? DONE : FILL;
                end else if (to_q == TO_LAST) begin
                    to_d    = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            DONE: begin
                cpu_rst_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            verify_q  <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            count_q   <= '0;
            to_q      <= '0;
            err_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            verify_q  <= verify_d;
            base_q    <= base_d;
            len_q     <= len_d;
            count_q   <= count_d;
            to_q      <= to_d;
            err_q     <= err_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    // Reset gates the strobe combinationally so the bus cycle is abandoned
    // in the very cycle reset is sampled, not one cycle later.
    assign o_wb_stb  = (state_q == BUS) & ~i_rst;
    assign o_wb_we   = (state_q == BUS) & ~verify_q;
    assign o_wb_adr  = base_q + count_q[AW-3:0];
    assign o_wb_dat  = w_word;
    assign o_wb_sel  = SEL_ALL;
    assign o_done    = (state_q == DONE) & ~i_rst;
    assign o_busy    = ((state_q != IDLE) | w_start_acc) & ~i_rst;
    assign o_cpu_rst = cpu_rst_q | w_start_acc | i_rst;
    assign o_err     = err_q;

endmodule

`default_nettype wire
